// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM state encoding, reset PC default,
// instruction-field constants and a small PC helper.
// Imported by fetch_unit.
package mips_pkg;

  // Fetch FSM state encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;

  // Opcodes / function codes that produce a next-PC override
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] FUNCT_JR    = 6'h08;

  // Sequential next PC; wraps modulo 2^32 with no flag.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// captures the returned word into the IF/ID register and honours next-PC
// redirects (J/JAL/JR), discarding any response already in flight.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   redir_valid, redir_pc            next-PC override
//   imem_req_valid/addr/ready        registered memory request channel
//   imem_rsp_valid/data              memory response (cannot be stalled)
//   ifid_valid/ir/pc4, ifid_ready    IF/ID register and decode handshake
//   fetch_misalign                   only when FETCH_MISALIGN_EN is defined
//
// Build option FETCH_MISALIGN_EN: a misaligned redirect pulses fetch_misalign
// and parks the unit in IDLE until an aligned redirect arrives. Without it the
// low two bits of redir_pc are ignored.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc4,
  input  logic        ifid_ready
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_misalign
`endif
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        req_valid_q;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_ir_q, ifid_ir_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        rsp_pending;
  logic [31:0] redir_target;

`ifdef FETCH_MISALIGN_EN
  logic halt_q, halt_d;
  logic misalign_q, misalign_d;
  logic redir_misaligned;

  assign redir_misaligned = |redir_pc[1:0];
  assign redir_target     = redir_pc;
  assign fetch_misalign   = misalign_q;
`else
  logic unused_redir_lsb;

  assign unused_redir_lsb = ^redir_pc[1:0];
  assign redir_target     = {redir_pc[31:2], 2'b00};
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    ifid_valid_d = ifid_valid_q;
    ifid_ir_d    = ifid_ir_q;
    ifid_pc4_d   = ifid_pc4_q;
    rsp_pending  = 1'b0;
`ifdef FETCH_MISALIGN_EN
    halt_d       = halt_q;
    misalign_d   = 1'b0;
`endif

    if (ifid_ready) begin
      ifid_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
`ifdef FETCH_MISALIGN_EN
        state_d = halt_q ? StIdle : StReq;
`else
        state_d = StReq;
`endif
      end
      StReq: begin
        if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          if (kill_q) begin
            // Response belongs to a redirected-away request: drop it.
            kill_d  = 1'b0;
`ifdef FETCH_MISALIGN_EN
            state_d = halt_q ? StIdle : StReq;
`else
            state_d = StReq;
`endif
          end else begin
            ifid_valid_d = 1'b1;
            ifid_ir_d    = imem_rsp_data;
            ifid_pc4_d   = pc_plus4(pc_q);
            pc_d         = pc_plus4(pc_q);
            // Only keep fetching if decode is draining the IF/ID register.
            state_d      = ifid_ready ? StReq : StHold;
          end
        end
      end
      StHold: begin
        if (ifid_ready) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides everything above. If a response is still owed by
    // memory, wait for it (flagged for discard) so only one is ever in flight.
    if (redir_valid) begin
      rsp_pending  = ((state_q == StWait) && !imem_rsp_valid) ||
                     ((state_q == StReq) && imem_req_ready);
      ifid_valid_d = 1'b0;
      kill_d       = rsp_pending;
      pc_d         = redir_target;
      state_d      = rsp_pending ? StWait : StReq;
`ifdef FETCH_MISALIGN_EN
      halt_d     = redir_misaligned;
      misalign_d = redir_misaligned;
      if (redir_misaligned) begin
        pc_d    = pc_q;
        state_d = rsp_pending ? StWait : StIdle;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_ir_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      req_valid_q  <= (state_d == StReq);
      ifid_valid_q <= ifid_valid_d;
      ifid_ir_q    <= ifid_ir_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      halt_q     <= halt_d;
      misalign_q <= misalign_d;
    end
  end
`endif

  // pc_q only changes alongside a state update, so in REQ it is the address.
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign ifid_valid     = ifid_valid_q;
  assign ifid_ir        = ifid_ir_q;
  assign ifid_pc4       = ifid_pc4_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 redir_valid  in  1  next-PC override (J, JAL, JR target) valid this cycle.
REQ-005 redir_pc  in  32  override target address.
REQ-006 imem_req_valid  out  1  instruction memory request valid.
REQ-007 imem_req_addr  out  32  request word address (byte address, low 2 bits zero).
REQ-008 imem_req_ready  in  1  memory accepts request.
REQ-009 imem_rsp_valid  in  1  instruction word returned.
REQ-010 imem_rsp_data  in  32  returned instruction.
REQ-011 ifid_valid  out  1  IF/ID register holds a live instruction.
REQ-012 ifid_ir  out  32  fetched instruction.
REQ-013 ifid_pc4  out  32  fetch PC + 4 (sequential next PC for the PC select).
REQ-014 ifid_ready  in  1  decode consumes IF/ID this cycle.

Function
REQ-015 FSM states IDLE, REQ, WAIT, HOLD; exactly one request outstanding at a time.
REQ-016 IDLE: one cycle after reset release, go to REQ with pc = RESET_PC.
REQ-017 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready go to WAIT.
REQ-018 WAIT: on imem_rsp_valid, load ifid_ir=rsp_data, ifid_pc4=pc+4, ifid_valid=1, pc<=pc+4; go to REQ if IF/ID is free next cycle, else HOLD.
REQ-019 HOLD: keep ifid_* stable, no request; on ifid_ready go to REQ.
REQ-020 ifid_ready with ifid_valid and no new response this cycle clears ifid_valid; a response arriving in the same cycle as ifid_ready replaces the entry and ifid_valid stays 1.
REQ-021 redir_valid in any state: pc<=redir_pc, ifid_valid<=0, go to REQ next cycle; redir wins over every simultaneous event.
REQ-022 redir_valid in WAIT: set kill flag; the pending response is discarded when it arrives, then the FSM issues redir_pc.
REQ-023 redir_valid in REQ with imem_req_ready the same cycle: the accepted request is killed as in REQ-022.
REQ-024 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-025 Latency: request to IF/ID valid = acceptance cycle + memory latency + 1.
REQ-026 imem_req_addr and imem_req_valid are registered (no combinational path from inputs).

Reset
REQ-027 During reset: state=IDLE, pc=RESET_PC, kill=0, imem_req_valid=0, ifid_valid=0, ifid_ir=0, ifid_pc4=0.
REQ-028 Reset during WAIT drops the outstanding response; a response arriving in IDLE is ignored.

Configuration
REQ-029 FETCH_MISALIGN_EN defined: extra output fetch_misalign (1 bit); a redir_pc with bits[1:0]!=0 sets it for one cycle, no request is issued, the FSM stays in IDLE until the next aligned redirect.
REQ-030 FETCH_MISALIGN_EN undefined: no fetch_misalign port; redir_pc[1:0] forced to 0.

Structure
REQ-031 FSM state encoding and RESET_PC default live in the shared mips package, with the instruction-field constants.
REQ-032 Flat module; no sub-module required.

Verification
REQ-033 Reset release, memory 1-cycle latency, ifid_ready=1 -> requests 0x0,0x4,0x8; ifid_pc4 0x4,0x8,0xC.
REQ-034 ifid_ready=0 for 5 cycles after first response -> HOLD, ifid_ir stable, no second request until ready.
REQ-035 redir_valid pc=0x0040_0100 while WAIT, response 0xDEADBEEF arrives -> discarded, next request addr 0x0040_0100.
REQ-036 redir_pc=0xFFFF_FFFC -> ifid_pc4=0x0000_0000, next request 0x0.
REQ-037 rst_n asserted mid-WAIT, late response -> ifid_valid stays 0, restart at RESET_PC.
REQ-038 With FETCH_MISALIGN_EN, redir_pc=0x102 -> fetch_misalign pulse 1 cycle, no imem_req_valid.
